ecc_enc_arbiter: RTL and testbench
==================================

# ecc_enc_arbiter

Round-robin arbiter that shares one combinational Hamming/ECC encoder (DATA_W data in, CODE_W check bits out) among PORT_N write ports of the multi-port cache. Each cycle it selects at most one requesting port and drives that port's word into the encoder. It captures the word and its check code in a one-entry output register. That register is drained toward the storage write path under a valid/ready handshake.

## Interface
- PORT_N, 4: number of requesting write ports (2..16)
- DATA_W, 32: data word width
- CODE_W, 6: encoder check-code width
- PTR_W, $clog2(PORT_N): port index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_vld  in  PORT_N  per-port word valid
- req_data  in  PORT_N*DATA_W  per-port word; port i at bits [i*DATA_W +: DATA_W]
- req_rdy  out  PORT_N  per-port accept, one-hot or zero; a beat transfers when req_vld[i] & req_rdy[i]
- enc_data  out  DATA_W  word driven to the encoder data input
- enc_vld  out  1  encoder input valid (= |req_rdy)
- enc_code  in  CODE_W  encoder check code, combinational from enc_data
- out_vld  out  1  output register holds a word
- out_rdy  in  1  downstream accepts the word
- out_data  out  DATA_W  registered word
- out_code  out  CODE_W  registered check code
- out_port  out  PTR_W  index of the source port
- req_last  in  PORT_N  last beat of a burst (present only with ECC_ARB_LOCK_EN)

## Operation
- Output register states: EMPTY (out_vld=0) and FULL (out_vld=1).
- load_ok = !out_vld | out_rdy. A grant is allowed only when load_ok is high, so drain and reload can happen in the same cycle.
- Arbitration is combinational. Starting at rr_ptr, the arbiter scans ports rr_ptr, rr_ptr+1, … modulo PORT_N. The first port with req_vld=1 is granted when load_ok=1. req_rdy is the one-hot grant, or all zero.
- enc_data is the granted port's req_data. It is all zero when no port is granted.
- On a grant to port g: out_data<=enc_data, out_code<=enc_code, out_port<=g, out_vld<=1, and rr_ptr<=(g+1) mod PORT_N. The modulo wraps correctly for non-power-of-2 PORT_N.
- out_vld clears when out_vld & out_rdy and no grant occurs in that cycle.
- With no grant, rr_ptr and the output register hold their values.
- req_rdy never depends on req_data. It depends only on req_vld, rr_ptr, out_vld, out_rdy and the lock state.
- The output register contents are stable while out_vld=1 and out_rdy=0.

## Timing
- Reset values: out_vld=0, out_data=0, out_code=0, out_port=0, rr_ptr=0, lock=0. req_rdy and enc_vld follow combinationally and are 0 while req_vld=0.
- Latency: a beat accepted at rising edge N shows out_vld=1 with its word and code after edge N.
- Throughput: 1 word/cycle while out_rdy=1.
- Full + out_rdy=0: all req_rdy=0, enc_vld=0, and output is held.
- Full + out_rdy=1 + request: drain and load occur on the same edge with no bubble.
- Reset asserted mid-transfer: the output register and rr_ptr clear immediately. The in-flight word is dropped, and requesters must re-present it.

## Configuration
- ECC_ARB_LOCK_EN defined: the req_last input exists, and a lock flag and lock_port register are added.
  - When port g is granted with req_last[g]=0, lock<=1 and lock_port<=g.
  - While locked, only lock_port can be granted, and other ports see req_rdy=0 even when lock_port is idle.
  - A granted beat with req_last=1 clears lock and advances rr_ptr to g+1. Non-last beats leave rr_ptr unchanged.
  - Reset clears lock.
- ECC_ARB_LOCK_EN undefined: req_last is absent, and every beat is re-arbitrated independently as described above.

## Test plan
- Single port: port 2 presents 0xDEADBEEF with out_rdy=1.
  - Expect req_rdy=4'b0100.
  - Next cycle out_vld=1, out_data=0xDEADBEEF, out_port=2, and out_code equals the encoder's output for 0xDEADBEEF.
- Fairness: all 4 ports hold req_vld=1 with out_rdy=1 for 8 cycles.
  - Expect grant order 0,1,2,3,0,1,2,3 and out_vld continuously 1.
- Backpressure: fill the register from port 1, then hold out_rdy=0 for 5 cycles with port 3 requesting.
  - Expect req_rdy=0 and out_data/out_code/out_port stable.
  - Raise out_rdy: port 3 loads on the same edge as the drain.
- Wrap with PORT_N=3: rr_ptr=2, and ports 0 and 2 request.
  - Expect port 2 granted, then port 0, with rr_ptr wrapping to 0 and then 1.
- Reset mid-operation: assert reset while out_vld=1 and out_rdy=0.
  - Expect out_vld=0, out_data=0, out_code=0, out_port=0 asynchronously.
  - After release, the first requester is chosen starting from port 0.
- Lock mode (ECC_ARB_LOCK_EN): port 1 sends 3 beats with req_last=0,0,1 while port 0 requests continuously.
  - Expect port 0 to have req_rdy=0 until port 1's last beat is accepted.
  - Then port 2 or later is considered first, so port 0 is granted next if it is the only requester.

Source files
------------

// File: rtl/ecc_enc_arbiter.sv
// ecc_enc_arbiter
//   Round-robin arbiter that shares one external combinational ECC encoder
//   among PORT_N write ports. A granted word goes through the encoder and is
//   captured, with its check code and source port, in a one-entry output register.
//
// Handshake: a beat transfers on a rising edge when valid and ready are both high.
//   Upstream:   req_vld[i] & req_rdy[i].
//   Downstream: out_vld & out_rdy.
//   req_rdy is one-hot or zero. It never looks at req_data.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   req_vld/req_data  per-port request word (port i at [i*DATA_W +: DATA_W])
//   req_last          last beat of a burst (ECC_ARB_LOCK_EN builds only)
//   req_rdy           per-port one-hot grant
//   enc_data/enc_vld  word and valid driven to the external encoder
//   enc_code          check code returned combinationally by the encoder
//   out_vld/out_rdy   output register handshake
//   out_data/out_code/out_port  registered word, code and source port
//   o_dbg_state       output register state (0 = EMPTY, 1 = FULL)
//
// Optional feature: define ECC_ARB_LOCK_EN to hold the grant on one port
// until that port presents a beat with req_last=1.
module ecc_enc_arbiter #(
  parameter int PORT_N = 4,
  parameter int DATA_W = 32,
  parameter int CODE_W = 6,
  localparam int PTR_W = $clog2(PORT_N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORT_N-1:0]        req_vld,
  input  logic [PORT_N*DATA_W-1:0] req_data,
`ifdef ECC_ARB_LOCK_EN
  input  logic [PORT_N-1:0]        req_last,
`endif
  output logic [PORT_N-1:0]        req_rdy,
  output logic [DATA_W-1:0]        enc_data,
  output logic                     enc_vld,
  input  logic [CODE_W-1:0]        enc_code,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic [CODE_W-1:0]        out_code,
  output logic [PTR_W-1:0]         out_port,
  output logic                     o_dbg_state
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_data;
  logic [CODE_W-1:0]  r_code;
  logic [PTR_W-1:0]   r_port;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic               w_load_ok;
  logic [PORT_N-1:0]  w_elig;
  logic [PORT_N-1:0]  w_grant;
  logic               w_gnt_any;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [PTR_W:0]     w_scan;

`ifdef ECC_ARB_LOCK_EN
  logic               r_lock;
  logic [PTR_W-1:0]   r_lock_port;

  // While locked, only the lock owner may win, even if it is idle this cycle.
  assign w_elig = r_lock ? (req_vld & (PORT_N'(1) << r_lock_port)) : req_vld;
`else
  assign w_elig = req_vld;
`endif

  // Loading is allowed when the register is empty or is being drained this cycle.
  assign w_load_ok = (r_state == ST_EMPTY) | out_rdy;

  // Scan rr_ptr, rr_ptr+1, ... modulo PORT_N. An extra bit on w_scan keeps the
  // wrap correct for non-power-of-2 PORT_N.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < PORT_N; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_scan >= (PTR_W+1)'(PORT_N)) w_scan = w_scan - (PTR_W+1)'(PORT_N);
      if (!w_gnt_any && w_load_ok && w_elig[w_scan[PTR_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    enc_data = '0;
    for (int i = 0; i < PORT_N; i++) begin
      if (w_grant[i]) enc_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_next_ptr = (w_gnt_idx == PTR_W'(PORT_N-1)) ? '0 : w_gnt_idx + PTR_W'(1);

  assign req_rdy     = w_grant;
  assign enc_vld     = w_gnt_any;
  assign out_vld     = (r_state == ST_FULL);
  assign out_data    = r_data;
  assign out_code    = r_code;
  assign out_port    = r_port;
  assign o_dbg_state = logic'(r_state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_data      <= '0;
      r_code      <= '0;
      r_port      <= '0;
      r_rr_ptr    <= '0;
`ifdef ECC_ARB_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_port <= '0;
`endif
    end else if (w_gnt_any) begin
      // A grant covers both a load into EMPTY and a drain-and-reload from FULL.
      r_state <= ST_FULL;
      r_data  <= enc_data;
      r_code  <= enc_code;
      r_port  <= w_gnt_idx;
`ifdef ECC_ARB_LOCK_EN
      if (req_last[w_gnt_idx]) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= w_next_ptr;
      end else begin
        r_lock      <= 1'b1;
        r_lock_port <= w_gnt_idx;
      end
`else
      r_rr_ptr <= w_next_ptr;
`endif
    end else if ((r_state == ST_FULL) && out_rdy) begin
      r_state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_ecc_enc_arbiter.sv
// tb_ecc_enc_arbiter
//   Runs directed scenarios on a 4-port and a 3-port instance, then runs
//   randomized traffic on the 4-port instance against a queue-based model.
module tb_ecc_enc_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam int PW = 2;
  localparam int QW = PW + CW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 4-port instance ----------------
  logic [N-1:0]    req_vld = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_rdy;
  logic [DW-1:0]   enc_data;
  logic            enc_vld;
  logic [CW-1:0]   enc_code;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_code;
  logic [PW-1:0]   out_port;
  logic            dbg_state;
`ifdef ECC_ARB_LOCK_EN
  logic [N-1:0]    req_last = '1;
  logic [2:0]      b_req_last = '1;
`endif

  // ---------------- 3-port instance (wrap check) ----------------
  logic [2:0]      b_req_vld = '0;
  logic [3*DW-1:0] b_req_data = '0;
  logic [2:0]      b_req_rdy;
  logic [DW-1:0]   b_enc_data;
  logic            b_enc_vld;
  logic [CW-1:0]   b_enc_code;
  logic            b_out_vld;
  logic            b_out_rdy = 1'b0;
  logic [DW-1:0]   b_out_data;
  logic [CW-1:0]   b_out_code;
  logic [1:0]      b_out_port;
  logic            b_dbg_state;

  // Encoder: Hamming-style parity over positions (index+1), plus overall parity.
  function automatic logic [CW-1:0] enc_fn(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DW; i++)
      for (int j = 0; j < CW-1; j++)
        if (((i + 1) >> j) & 1) c[j] = c[j] ^ d[i];
    c[CW-1] = ^d;
    return c;
  endfunction

  assign enc_code   = enc_fn(enc_data);
  assign b_enc_code = enc_fn(b_enc_data);

  ecc_enc_arbiter #(.PORT_N(N), .DATA_W(DW), .CODE_W(CW)) u_dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_data(req_data),
`ifdef ECC_ARB_LOCK_EN
    .req_last(req_last),
`endif
    .req_rdy(req_rdy), .enc_data(enc_data), .enc_vld(enc_vld), .enc_code(enc_code),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_code(out_code),
    .out_port(out_port), .o_dbg_state(dbg_state)
  );

  ecc_enc_arbiter #(.PORT_N(3), .DATA_W(DW), .CODE_W(CW)) u_dut3 (
    .clk(clk), .reset(reset), .req_vld(b_req_vld), .req_data(b_req_data),
`ifdef ECC_ARB_LOCK_EN
    .req_last(b_req_last),
`endif
    .req_rdy(b_req_rdy), .enc_data(b_enc_data), .enc_vld(b_enc_vld), .enc_code(b_enc_code),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_data(b_out_data), .out_code(b_out_code),
    .out_port(b_out_port), .o_dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [DW-1:0] d);
    req_data[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_vld = '0;
    out_rdy = 1'b0;
    b_req_vld = '0;
    b_out_rdy = 1'b0;
`ifdef ECC_ARB_LOCK_EN
    req_last = '1;
`endif
    #2;
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_port", out_port, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_enc_vld", enc_vld, 0);
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model state ----------------
  int   m_ptr;
  bit   m_full;
  bit   m_lock;
  int   m_lock_port;

  initial begin
    // ---- single port ----
    do_reset();
    set_port(2, 32'hDEADBEEF);
    req_vld = 4'b0100;
    out_rdy = 1'b1;
    #1;
    check("single_rdy", req_rdy, 4'b0100);
    check("single_enc_vld", enc_vld, 1);
    check("single_enc_data", enc_data, 32'hDEADBEEF);
    tick();
    req_vld = '0;
    check("single_out_vld", out_vld, 1);
    check("single_out_data", out_data, 32'hDEADBEEF);
    check("single_out_port", out_port, 2);
    check("single_out_code", out_code, enc_fn(32'hDEADBEEF));

    // ---- fairness ----
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 32'h1000_0000 * (i + 1) + 32'h55);
    req_vld = 4'hF;
    out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_rdy", req_rdy, 4'(1) << (k % 4));
      tick();
      check("fair_out_vld", out_vld, 1);
      check("fair_out_port", out_port, k % 4);
      check("fair_out_data", out_data, 32'h1000_0000 * ((k % 4) + 1) + 32'h55);
    end
    req_vld = '0;

    // ---- backpressure ----
    do_reset();
    set_port(1, 32'hA5A5_0001);
    set_port(3, 32'h3333_CAFE);
    req_vld = 4'b0010;
    out_rdy = 1'b0;
    #1;
    check("bp_fill_rdy", req_rdy, 4'b0010);
    tick();
    req_vld = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", req_rdy, 0);
      check("bp_enc_vld", enc_vld, 0);
      tick();
      check("bp_vld", out_vld, 1);
      check("bp_data", out_data, 32'hA5A5_0001);
      check("bp_code", out_code, enc_fn(32'hA5A5_0001));
      check("bp_port", out_port, 1);
    end
    out_rdy = 1'b1;
    #1;
    check("bp_release_rdy", req_rdy, 4'b1000);
    tick();
    check("bp_reload_vld", out_vld, 1);
    check("bp_reload_port", out_port, 3);
    check("bp_reload_data", out_data, 32'h3333_CAFE);

    // ---- reset mid-operation (pointer moved past 0 first) ----
    set_port(2, 32'h2222_0002);
    req_vld = 4'b0100;
    tick();
    req_vld = '0;
    out_rdy = 1'b0;
    tick();
    check("mid_pre_vld", out_vld, 1);
    reset = 1'b1;
    #2;
    check("mid_rst_vld", out_vld, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_code", out_code, 0);
    check("mid_rst_port", out_port, 0);
    reset = 1'b0;
    set_port(0, 32'h0000_F00D);
    req_vld = 4'b1001;
    out_rdy = 1'b1;
    #1;
    check("mid_after_rdy", req_rdy, 4'b0001);
    tick();
    check("mid_after_port", out_port, 0);
    req_vld = '0;

    // ---- wrap on the 3-port instance ----
    do_reset();
    b_req_data = {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    b_out_rdy = 1'b1;
    b_req_vld = 3'b010;
    #1;
    check("wrap_setup_rdy", b_req_rdy, 3'b010);
    tick();
    b_req_vld = 3'b101;
    #1;
    check("wrap_rdy_p2", b_req_rdy, 3'b100);
    tick();
    check("wrap_port_p2", b_out_port, 2);
    check("wrap_data_p2", b_out_data, 32'hC2C2_0002);
    #1;
    check("wrap_rdy_p0", b_req_rdy, 3'b001);
    tick();
    check("wrap_port_p0", b_out_port, 0);
    #1;
    check("wrap_rdy_from1", b_req_rdy, 3'b100);
    tick();
    check("wrap_port_from1", b_out_port, 2);
    b_req_vld = '0;

`ifdef ECC_ARB_LOCK_EN
    // ---- burst lock ----
    do_reset();
    out_rdy = 1'b1;
    req_last = 4'hF;
    req_vld = 4'b0001;
    tick();
    req_vld = 4'b0011;
    req_last = 4'b1101;
    #1;
    check("lock_beat0_rdy", req_rdy, 4'b0010);
    tick();
    check("lock_beat0_port", out_port, 1);
    req_vld = 4'b0001;
    #1;
    check("lock_idle_rdy", req_rdy, 0);
    tick();
    req_vld = 4'b0011;
    #1;
    check("lock_beat1_rdy", req_rdy, 4'b0010);
    tick();
    req_last = 4'hF;
    #1;
    check("lock_last_rdy", req_rdy, 4'b0010);
    tick();
    check("lock_last_port", out_port, 1);
    #1;
    check("unlock_rdy", req_rdy, 4'b0001);
    tick();
    check("unlock_port", out_port, 0);
    req_vld = '0;
`endif

    // ---- randomized traffic against the model ----
    do_reset();
    m_ptr = 0;
    m_full = 0;
    m_lock = 0;
    m_lock_port = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic [N-1:0]  exp_rdy;
      logic [DW-1:0] exp_data;
      req_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) set_port(i, $urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
`ifdef ECC_ARB_LOCK_EN
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 2) != 0);
`endif
      #1;
      g = -1;
      if (!m_full || out_rdy) begin
        if (m_lock) begin
          if (req_vld[m_lock_port]) g = m_lock_port;
        end else begin
          for (int k = 0; k < N; k++)
            if (g < 0 && req_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_rdy  = (g >= 0) ? (4'(1) << g) : 4'b0;
      exp_data = (g >= 0) ? req_data[g*DW +: DW] : '0;
      check("rnd_rdy", req_rdy, exp_rdy);
      check("rnd_enc_vld", enc_vld, (g >= 0));
      check("rnd_enc_data", enc_data, exp_data);
      if (g >= 0) begin
        if (m_full) void'(exp_q.pop_front());
        exp_q.push_back({PW'(g), enc_fn(exp_data), exp_data});
        m_full = 1;
`ifdef ECC_ARB_LOCK_EN
        if (req_last[g]) begin
          m_lock = 0;
          m_ptr = (g + 1) % N;
        end else begin
          m_lock = 1;
          m_lock_port = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else if (m_full && out_rdy) begin
        void'(exp_q.pop_front());
        m_full = 0;
      end
      tick();
      check("rnd_out_vld", out_vld, m_full);
      if (m_full) begin
        check("rnd_out_port", out_port, exp_q[0][QW-1 -: PW]);
        check("rnd_out_code", out_code, exp_q[0][DW +: CW]);
        check("rnd_out_data", out_data, exp_q[0][DW-1:0]);
      end
    end
    req_vld = '0;
    out_rdy = 1'b0;

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
